// File: rtl/shift_latch_loader.sv
// Serial-to-parallel loader that drives a downstream transparent D-latch bank.
// A word is shifted in MSB first, presented on par_d with one cycle of setup,
// strobed into the latches for STROBE_CYCLES cycles, then held for one cycle
// before done pulses. STROBE_CYCLES must lie in 1..15 (4-bit strobe counter).
// WIDTH must be at least 2.
module shift_latch_loader #(
    parameter int WIDTH         = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] par_d,
    output logic             latch_c,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [3:0]    STRB_LOAD = 4'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]   bit_cnt;
    logic [3:0]      strb_cnt;
    logic            last_bit;

    // The WIDTH-th valid bit is being accepted this cycle.
    assign last_bit = (state == S_SHIFT) && ser_valid && (bit_cnt == LAST_BIT);

    // busy is a pure decode of the registered state, so it falls with reset.
    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; start is only looked at in IDLE, so requests made
    // while busy are dropped rather than queued.
    always_comb begin
        // NOTE: default first so no path leaves state_nx unassigned, which
        // would otherwise infer a latch.
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_SHIFT;
            S_SHIFT:  if (last_bit) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_STROBE;
            S_STROBE: if (strb_cnt == 4'd0) state_nx = S_HOLD;
            S_HOLD:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Datapath and registered outputs: shifter, counters, par_d, latch_c, done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            strb_cnt <= '0;
            par_d    <= '0;
            latch_c  <= 1'b0;
            done     <= 1'b0;
        end else begin
            // latch_c follows the next state so it is high exactly in STROBE.
            latch_c <= (state_nx == S_STROBE);
            // The first IDLE cycle after HOLD carries the done pulse.
            done    <= (state == S_HOLD);
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg    <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (ser_valid) begin
                        sreg    <= {sreg[WIDTH-2:0], ser_in};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    // par_d only moves here, while the latches are closed.
                    if (last_bit) begin
                        par_d <= {sreg[WIDTH-2:0], ser_in};
                    end
                end
                S_SETUP: begin
                    // Reload on every entry to STROBE; exit when it reaches 0.
                    strb_cnt <= STRB_LOAD;
                end
                S_STROBE: begin
                    if (strb_cnt != 4'd0) begin
                        strb_cnt <= strb_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_latch_loader.sv
// Self-checking bench for shift_latch_loader: a default instance (WIDTH=8,
// STROBE_CYCLES=2) driven from a vector table plus directed corner sequences,
// and a WIDTH=4 / STROBE_CYCLES=1 instance for the parameter sweep.
module tb_shift_latch_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, ser_in, ser_valid;
    logic [7:0] par_d;
    logic       latch_c, busy, done;

    logic       start4, ser_in4, ser_valid4;
    logic [3:0] par_d4;
    logic       latch_c4, busy4, done4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_latch_loader #(.WIDTH(8), .STROBE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ser_in(ser_in),
        .ser_valid(ser_valid), .par_d(par_d), .latch_c(latch_c),
        .busy(busy), .done(done)
    );

    shift_latch_loader #(.WIDTH(4), .STROBE_CYCLES(1)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .ser_in(ser_in4),
        .ser_valid(ser_valid4), .par_d(par_d4), .latch_c(latch_c4),
        .busy(busy4), .done(done4)
    );

    // Behavioural model of the downstream transparent latch bank.
    logic [7:0] lat_q;
    always_latch begin
        if (latch_c) lat_q = par_d;
    end

    // Free-running observers sampled mid-cycle; tests compare deltas.
    int         cyc = 0;
    int         done_cnt = 0, strb_cnt = 0, glitch_cnt = 0, last_done_cyc = 0;
    int         done_cnt4 = 0, strb_cnt4 = 0, last_done_cyc4 = 0;
    logic [7:0] prev_par = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done)    begin done_cnt = done_cnt + 1; last_done_cyc = cyc; end
        if (latch_c) strb_cnt = strb_cnt + 1;
        if (latch_c && (par_d !== prev_par)) glitch_cnt = glitch_cnt + 1;
        prev_par = par_d;
        if (done4)    begin done_cnt4 = done_cnt4 + 1; last_done_cyc4 = cyc; end
        if (latch_c4) strb_cnt4 = strb_cnt4 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift one 8-bit word into the default DUT, which must already be in SHIFT.
    // mark is the observer cycle index of the cycle that presents the last bit.
    task automatic load8(input logic [7:0] w, input bit gapped, input logic [7:0] old,
                         output int mark);
        for (int i = 7; i >= 0; i--) begin
            if (gapped && i != 7) begin
                ser_valid = 1'b0;
                ser_in    = ~w[i];
                tick();
            end
            if (i == 0) begin
                check("par_hold_pre_last", 32'(par_d), 32'(old));
                check("busy_in_shift", 32'(busy), 32'd1);
                mark = cyc + 1;
            end
            ser_valid = 1'b1;
            ser_in    = w[i];
            tick();
        end
        ser_valid = 1'b0;
        check("par_d_setup", 32'(par_d), 32'(w));
        check("latch_c_setup", 32'(latch_c), 32'd0);
    endtask

    typedef struct {
        logic [7:0] word;
        bit         gapped;
        bit         junk;
        logic [7:0] exp_par;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] prev_word;
    logic [3:0] w4;
    int         mark, mark4, d0, s0, g0;

    initial begin
        vecs[0] = '{word: 8'hB2, gapped: 1'b0, junk: 1'b0, exp_par: 8'hB2};
        vecs[1] = '{word: 8'h5A, gapped: 1'b1, junk: 1'b0, exp_par: 8'h5A};
        vecs[2] = '{word: 8'hC3, gapped: 1'b0, junk: 1'b1, exp_par: 8'hC3};
        vecs[3] = '{word: 8'h0F, gapped: 1'b1, junk: 1'b1, exp_par: 8'h0F};

        rst = 1'b1; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
        start4 = 1'b0; ser_in4 = 1'b0; ser_valid4 = 1'b0;
        #3;
        check("rst_par_d", 32'(par_d), 32'd0);
        check("rst_latch_c", 32'(latch_c), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_par_d", 32'(par_d), 32'd0);

        // Table-driven loads: plain, gapped, and with stray ser_valid outside SHIFT.
        prev_word = 8'h00;
        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            s0 = strb_cnt;
            if (vecs[v].junk) begin
                ser_valid = 1'b1; ser_in = 1'b1;
                repeat (2) tick();
            end
            start = 1'b1;
            tick();
            start = 1'b0;
            load8(vecs[v].word, vecs[v].gapped, prev_word, mark);
            if (vecs[v].junk) begin
                ser_valid = 1'b1; ser_in = 1'b1;
            end
            repeat (6) tick();
            ser_valid = 1'b0;
            check("vec_done_pulses", 32'(done_cnt - d0), 32'd1);
            check("vec_strobe_cycles", 32'(strb_cnt - s0), 32'd2);
            check("vec_done_latency", 32'(last_done_cyc - mark), 32'd5);
            check("vec_latch_q", 32'(lat_q), 32'(vecs[v].exp_par));
            check("vec_par_d_held", 32'(par_d), 32'(vecs[v].exp_par));
            check("vec_busy_end", 32'(busy), 32'd0);
            check("vec_done_end", 32'(done), 32'd0);
            prev_word = vecs[v].exp_par;
        end

        // Busy rejection: start pulsed during SHIFT and during STROBE.
        d0 = done_cnt;
        s0 = strb_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                check("rej_par_hold", 32'(par_d), 32'h0F);
                mark = cyc + 1;
            end
            ser_valid = 1'b1;
            ser_in    = w8_bit(8'h3C, i);
            start     = (i == 5);
            tick();
        end
        start = 1'b0; ser_valid = 1'b0;
        check("rej_par_setup", 32'(par_d), 32'h3C);
        tick();
        check("rej_latch_c_strobe", 32'(latch_c), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("rej_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("rej_strobe_cycles", 32'(strb_cnt - s0), 32'd2);
        check("rej_no_queue_busy", 32'(busy), 32'd0);
        check("rej_par_d", 32'(par_d), 32'h3C);

        // Back-to-back loads with start held high.
        d0 = done_cnt;
        s0 = strb_cnt;
        g0 = glitch_cnt;
        start = 1'b1;
        tick();
        load8(8'hFF, 1'b0, 8'h3C, mark);
        repeat (4) tick();
        check("b2b_first_done", 32'(done), 32'd1);
        tick();
        check("b2b_restart_busy", 32'(busy), 32'd1);
        load8(8'h00, 1'b0, 8'hFF, mark);
        start = 1'b0;
        repeat (6) tick();
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("b2b_strobe_cycles", 32'(strb_cnt - s0), 32'd4);
        check("b2b_par_change_under_strobe", 32'(glitch_cnt - g0), 32'd0);
        check("b2b_done_latency", 32'(last_done_cyc - mark), 32'd5);
        check("b2b_latch_q", 32'(lat_q), 32'h00);

        // Reset in the first STROBE cycle, then an immediate start after release.
        start = 1'b1;
        tick();
        start = 1'b0;
        load8(8'hA5, 1'b0, 8'h00, mark);
        tick();
        check("mid_latch_c_before_rst", 32'(latch_c), 32'd1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_latch_c", 32'(latch_c), 32'd0);
        check("mid_rst_par_d", 32'(par_d), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_after_rst", 32'(busy), 32'd1);
        load8(8'h81, 1'b0, 8'h00, mark);
        repeat (6) tick();
        check("post_rst_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("post_rst_par_d", 32'(par_d), 32'h81);

        // Parameter sweep: WIDTH=4, STROBE_CYCLES=1, word 4'h9.
        d0 = done_cnt4;
        s0 = strb_cnt4;
        w4 = 4'h9;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) mark4 = cyc + 1;
            ser_valid4 = 1'b1;
            ser_in4    = w4[i];
            tick();
        end
        ser_valid4 = 1'b0;
        check("w4_par_d_setup", 32'(par_d4), 32'h9);
        check("w4_latch_c_setup", 32'(latch_c4), 32'd0);
        repeat (5) tick();
        check("w4_strobe_cycles", 32'(strb_cnt4 - s0), 32'd1);
        check("w4_done_pulses", 32'(done_cnt4 - d0), 32'd1);
        check("w4_done_latency", 32'(last_done_cyc4 - mark4), 32'd4);
        check("w4_par_d_held", 32'(par_d4), 32'h9);
        check("w4_busy_end", 32'(busy4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic w8_bit(input logic [7:0] w, input int i);
        return w[i];
    endfunction

endmodule
